// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
//   mode_e  : routing mode (addressed by select, or round-robin)
//   rr_next : wrap-around increment used by the round-robin pointer
package stream_demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  // Next round-robin target: ptr + 1, wrapping from n_ch - 1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n_ch);
    return (ptr + 1 >= n_ch) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/ready holding register for a single output lane.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture data_in this edge (only asserted when can_load is high)
//   data_in    : payload to capture
//   out_valid  : lane holds a beat
//   out_ready  : consumer accepts the held beat this cycle
//   out_data   : held payload; keeps its last value after draining
//   can_load   : register is empty or is draining this cycle
module demux_chan_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              can_load
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Drain and refill in the same cycle is allowed, so a full lane with a
  // ready consumer still accepts a new beat.
  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered, handshaked 1-to-N stream demultiplexer.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   mode        : 0 = route by in_sel, 1 = round-robin via rr_ptr
//   in_valid/in_ready/in_data/in_sel : producer stream
//   out_valid/out_ready/out_data     : N_CH consumer lanes, lane i at [i*DATA_W +: DATA_W]
//   rr_ptr      : next round-robin target
//   drop_cnt    : saturating count of beats with an out-of-range select
//   err_sticky  : set on any dropped beat
//   clr_stats   : synchronous clear of drop_cnt and err_sticky (wins over a drop)
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     err_sticky,
  input  logic                     clr_stats
);

  localparam logic [SEL_W:0] NumCh = (SEL_W + 1)'(N_CH);

  logic [SEL_W-1:0] target;
  logic             in_range;
  logic             accept;
  logic             drop;
  logic [N_CH-1:0]  can_load;
  logic [N_CH-1:0]  load;

  logic [SEL_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             err_q;

  always_comb begin
    target   = (mode_e'(mode) == MODE_RR) ? rr_ptr_q : in_sel;
    in_range = {1'b0, target} < NumCh;
    // Out-of-range targets are swallowed, so they are always ready.
    in_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (target == SEL_W'(i)) begin
        in_ready = can_load[i];
      end
    end
    accept = in_valid && in_ready;
    drop   = accept && !in_range;
    load   = '0;
    for (int i = 0; i < N_CH; i++) begin
      load[i] = accept && (target == SEL_W'(i));
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    demux_chan_reg #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .data_in  (in_data),
      .out_valid(out_valid[i]),
      .out_ready(out_ready[i]),
      .out_data (out_data[i*DATA_W +: DATA_W]),
      .can_load (can_load[i])
    );
  end

  // rr_ptr only ever holds in-range values, so an RR accept is never a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (accept && (mode_e'(mode) == MODE_RR)) begin
      rr_ptr_q <= SEL_W'(rr_next(32'(rr_ptr_q), N_CH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (drop) begin
      err_q <= 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign rr_ptr     = rr_ptr_q;
  assign drop_cnt   = drop_cnt_q;
  assign err_sticky = err_q;

endmodule

// File: doc/stream_demux_1xn.md
Name: stream_demux_1xn

Overview:
- Registered, handshaked 1-to-N demultiplexer. Successor to the combinational 1x4 demux.
- Parametrised in data width and channel count.
- Two routing modes: addressed by select, or round-robin distribution.
- Per-channel 1-entry output register, valid/ready backpressure, out-of-range select detection with saturating drop counter.
- Sits between a single producer stream and N consumer lanes.

Parameters:
- N_CH, 4, number of output channels (2..16).
- DATA_W, 8, payload width in bits.
- CNT_W, 8, width of drop counter.
- SEL_W, $clog2(N_CH), localparam, select width; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  routing mode: 0 = addressed by in_sel, 1 = round-robin.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  target channel in addressed mode; ignored in round-robin mode.
- out_valid  output  N_CH  per-channel valid.
- out_ready  input  N_CH  per-channel ready.
- out_data  output  N_CH*DATA_W  flattened payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- rr_ptr  output  SEL_W  next round-robin target.
- drop_cnt  output  CNT_W  count of dropped beats, saturating.
- err_sticky  output  1  set on first dropped beat.
- clr_stats  input  1  synchronous clear of drop_cnt and err_sticky.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0, err_sticky = 0. in_ready is combinational and therefore 1 in addressed mode with in-range select.
- Target channel t:
  - mode = 0: t = in_sel.
  - mode = 1: t = rr_ptr.
- Channel register i can load when out_valid[i] = 0, or when out_ready[i] = 1 in the same cycle (simultaneous drain and refill allowed).
- in_ready:
  - = 1 if t >= N_CH (drop path).
  - Otherwise = can_load[t].
  - Depends only on registered state, mode, in_sel and out_ready; no dependence on in_valid.
- Accept (in_valid && in_ready && t < N_CH):
  - Next edge: out_data[t] = in_data, out_valid[t] = 1.
  - Latency is 1 cycle from accept to out_valid.
  - No other channel is touched.
- Drain: out_valid[i] && out_ready[i] with no refill clears out_valid[i]. out_data[i] holds its last value.
- Hold: while out_valid[i] && !out_ready[i], out_data[i] is stable. No payload is ever overwritten.
- Round-robin:
  - rr_ptr advances only on an accepted beat in mode 1. It wraps N_CH-1 -> 0.
  - A stalled target channel blocks the input; the next channel is never skipped.
  - rr_ptr holds its value in mode 0.
  - Mode may change between beats; the new mode applies to the next evaluated beat.
- Out-of-range select (addressed mode, in_sel >= N_CH; only possible for non-power-of-2 N_CH):
  - Beat is accepted and discarded.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - err_sticky is set.
- clr_stats:
  - Next edge: drop_cnt = 0, err_sticky = 0.
  - If a drop occurs in the same cycle, clear wins; that drop is lost from the count.
- Reset mid-operation: all held beats are discarded, and outputs return to reset values immediately (asynchronous). Operation resumes on the first clk edge after rst_n deasserts.
- Multiple channels may be valid simultaneously; at most one channel loads per cycle.

Decomposition:
- Package stream_demux_pkg:
  - typedef for the mode enum (MODE_ADDR = 0, MODE_RR = 1).
  - Function computing wrap-around increment for rr_ptr.
- Sub-module demux_chan_reg: one 1-entry valid/ready holding register (DATA_W). Ports: load, data_in, out_valid, out_ready, out_data, can_load. Instantiated N_CH times in a generate loop.
- Top-level contains the target select, in_ready mux, rr_ptr and stats logic.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 4'b0000, drop_cnt = 0, err_sticky = 0, rr_ptr = 0 throughout.
- Addressed sweep (N_CH = 4, DATA_W = 8, out_ready = 4'b1111): in_data = 8'hA0+s for in_sel = 0,1,2,3 on consecutive cycles -> one cycle later out_valid is 0001, 0010, 0100, 1000 in turn, with out_data lane s = A0+s.
- Backpressure:
  - out_ready[2] = 0; send D1 then D2 to sel 2.
  - Expected: D1 held on lane 2, and in_ready = 0 while sel = 2.
  - Raise out_ready[2] -> D1 drained, D2 loaded in the same cycle, lane 2 shows D2 next cycle.
- Round-robin (mode = 1): 6 back-to-back beats 0x10..0x15, all ready -> lanes 0,1,2,3,0,1 receive them in order; rr_ptr ends at 2. Stall lane 1 -> input stalls, rr_ptr stays 1.
- Out-of-range (N_CH = 3): in_sel = 3 for 2 beats -> in_ready = 1, no out_valid, drop_cnt = 2, err_sticky = 1. clr_stats pulse -> both 0 next cycle.
- Mid-operation reset: lanes 0 and 3 valid and stalled, assert rst_n low between edges -> out_valid = 0 immediately. After release, a new beat to sel 3 appears after 1 cycle.
